// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates between a fetch port (IReq_FE) and a memory-stage
// port (DReq_ME) for a single external memory port (MemReq_SY/MemAck_SY).
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   IReq/IAddr/IData/IAck  fetch read port (_FE)
//   DReq/DWrite/DAddr/DWrDat/DRdDat/DAck  load/store port (_ME)
//   MemReq/MemWrite/MemAddr/MemWrDat/MemRdDat/MemAck  external port (_SY)
//   AnyStall               global pipeline stall
//   BusErr                 sticky timeout flag, cleared only by reset
//
// Parameter TIMEOUT_CYC: BUSY cycles without MemAck_SY before the transaction
// is aborted with zero data and BusErr set (1..65535).
//
// Optional macro MEM_ARBITER_RR_EN: when both sides request in IDLE, grant the
// side that lost the previous contested arbitration. Undefined: D beats I.
module mem_arbiter #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IReq_FE,
  input  logic [31:0] IAddr_FE,
  output logic [31:0] IData_FE,
  output logic        IAck_FE,
  input  logic        DReq_ME,
  input  logic        DWrite_ME,
  input  logic [31:0] DAddr_ME,
  input  logic [31:0] DWrDat_ME,
  output logic [31:0] DRdDat_ME,
  output logic        DAck_ME,
  output logic        MemReq_SY,
  output logic        MemWrite_SY,
  output logic [31:0] MemAddr_SY,
  output logic [31:0] MemWrDat_SY,
  input  logic [31:0] MemRdDat_SY,
  input  logic        MemAck_SY,
  output logic        AnyStall,
  output logic        BusErr
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYC);

  state_t      state, stateNext;
  logic [15:0] waitCnt;
  logic        busy;
  logic        grantI, grantD;
  logic        timeoutHit;
  logic        bothReq;

`ifdef MEM_ARBITER_RR_EN
  logic        lastD;  // 1 = D won the last contested arbitration
`endif

  assign busy      = (state == BUSY_I) || (state == BUSY_D);
  assign MemReq_SY = busy;
  assign bothReq   = IReq_FE & DReq_ME;
  // Acks are flops, so the stall is a cheap decode of registered state.
  assign AnyStall  = (IReq_FE & ~IAck_FE) | (DReq_ME & ~DAck_ME);
  // An ack in the same cycle as the limit wins over the timeout.
  assign timeoutHit = busy & ~MemAck_SY & ((waitCnt + 16'd1) == TIMEOUT_VAL);

  always_comb begin
    stateNext = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    case (state)
      IDLE: begin
`ifdef MEM_ARBITER_RR_EN
        if (bothReq) begin
          grantI = lastD;
          grantD = ~lastD;
        end else begin
          grantD = DReq_ME;
          grantI = IReq_FE;
        end
`else
        grantD = DReq_ME;
        grantI = IReq_FE & ~DReq_ME;
`endif
        if (grantD)      stateNext = BUSY_D;
        else if (grantI) stateNext = BUSY_I;
      end
      BUSY_I, BUSY_D: if (MemAck_SY || timeoutHit) stateNext = RESP;
      RESP:           stateNext = IDLE;
      default:        stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      waitCnt     <= '0;
      IAck_FE     <= 1'b0;
      DAck_ME     <= 1'b0;
      IData_FE    <= '0;
      DRdDat_ME   <= '0;
      MemWrite_SY <= 1'b0;
      MemAddr_SY  <= '0;
      MemWrDat_SY <= '0;
      BusErr      <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      lastD       <= 1'b0;
`endif
    end else begin
      state   <= stateNext;
      // One-cycle pulses, high exactly while in RESP for the served side.
      IAck_FE <= (state == BUSY_I) && (stateNext == RESP);
      DAck_ME <= (state == BUSY_D) && (stateNext == RESP);

      if (grantD) begin
        MemAddr_SY  <= DAddr_ME;
        MemWrite_SY <= DWrite_ME;
        MemWrDat_SY <= DWrDat_ME;
        waitCnt     <= '0;
      end else if (grantI) begin
        MemAddr_SY  <= IAddr_FE;
        MemWrite_SY <= 1'b0;
        MemWrDat_SY <= '0;
        waitCnt     <= '0;
      end

`ifdef MEM_ARBITER_RR_EN
      // Only contested grants move the flag; a lone request says nothing
      // about fairness between the two sides.
      if (state == IDLE && bothReq) lastD <= grantD;
`endif

      if (busy) begin
        if (MemAck_SY) begin
          if (state == BUSY_I)      IData_FE  <= MemRdDat_SY;
          else if (!MemWrite_SY)    DRdDat_ME <= MemRdDat_SY;
        end else begin
          waitCnt <= waitCnt + 16'd1;
          if (timeoutHit) begin
            BusErr <= 1'b1;
            // Stores never touch the load data register, even on abort.
            if (state == BUSY_I)    IData_FE  <= '0;
            else if (!MemWrite_SY)  DRdDat_ME <= '0;
          end
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: MemReq_SY cycles without MemAck_SY before abort, range 1..65535.
REQ-002 SHALL have ports:
- clk  input  1  clock; all state on posedge
- reset  input  1  synchronous, active-high
- IReq_FE  input  1  fetch read request, held until IAck_FE
- IAddr_FE  input  32  fetch byte address
- IData_FE  output  32  fetch read data, valid with IAck_FE
- IAck_FE  output  1  one-cycle fetch completion pulse
- DReq_ME  input  1  memory-stage request, held until DAck_ME
- DWrite_ME  input  1  1 = store, 0 = load
- DAddr_ME  input  32  data byte address
- DWrDat_ME  input  32  store data
- DRdDat_ME  output  32  load data, valid with DAck_ME
- DAck_ME  output  1  one-cycle data completion pulse
- MemReq_SY  output  1  external port request, held until MemAck_SY or abort
- MemWrite_SY  output  1  external write enable
- MemAddr_SY  output  32  external address
- MemWrDat_SY  output  32  external write data
- MemRdDat_SY  input  32  external read data, valid with MemAck_SY
- MemAck_SY  input  1  external completion, sampled only while MemReq_SY=1
- AnyStall  output  1  global pipeline stall
- BusErr  output  1  sticky timeout flag
REQ-003 SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, RESP.
REQ-005 IDLE: if DReq_ME=1 -> BUSY_D; else if IReq_FE=1 -> BUSY_I; else stay. Grant transition occurs at the clock edge; MemReq_SY=1 from the following cycle.
REQ-006 On grant SHALL latch addr/write/wrdat of the winner into MemAddr_SY/MemWrite_SY/MemWrDat_SY; these SHALL be stable while MemReq_SY=1.
REQ-007 BUSY_x: MemReq_SY=1; on MemAck_SY=1 capture MemRdDat_SY into the winner's data register -> RESP.
REQ-008 RESP: pulse IAck_FE or DAck_ME (exactly one) for one cycle, MemReq_SY=0 -> IDLE; minimum request-to-ack latency 3 cycles (MemAck_SY in first BUSY cycle).
REQ-009 IData_FE/DRdDat_ME SHALL hold last captured value until next capture; stores SHALL leave DRdDat_ME unchanged.
REQ-010 AnyStall = (IReq_FE & ~IAck_FE) | (DReq_ME & ~DAck_ME), combinational from registered acks.
REQ-011 A request still asserted in the cycle after its ack SHALL be treated as a new request.
REQ-012 16-bit wait counter SHALL clear on grant, increment each BUSY cycle without MemAck_SY; on reaching TIMEOUT_CYC -> RESP with data register loaded 0, BusErr set.
REQ-013 MemAck_SY and timeout in same cycle: MemAck_SY wins, BusErr unchanged.
REQ-014 MemAck_SY in IDLE or RESP SHALL be ignored.
REQ-015 BusErr SHALL remain 1 until reset.

Reset
REQ-016 reset=1 SHALL force IDLE, counter 0, all outputs 0 (incl. IData_FE, DRdDat_ME, BusErr) at the next edge, overriding any transaction in progress.
REQ-017 An aborted transaction SHALL NOT be acked; a MemAck_SY arriving after reset SHALL be ignored.

Configuration
REQ-018 Macro MEM_ARBITER_RR_EN defined: IDLE with both requests pending SHALL grant the side not granted last (1-bit last-grant flag, reset value = I, so D wins first); single request granted directly.
REQ-019 MEM_ARBITER_RR_EN undefined: fixed D-over-I priority per REQ-005, no last-grant flag.

Verification
REQ-020 Load: DReq_ME=1, DWrite_ME=0, DAddr_ME=0x100; MemAck_SY with MemRdDat_SY=0xDEADBEEF 2 cycles after MemReq_SY -> DAck_ME one pulse, DRdDat_ME=0xDEADBEEF, AnyStall=1 until ack cycle.
REQ-021 Same-cycle IReq_FE (0x400) and DReq_ME (store 0x200, data 0x12345678), ack each after 1 cycle -> without macro: D served first then I; with MEM_ARBITER_RR_EN and a second simultaneous pair: D, I, then I, D.
REQ-022 TIMEOUT_CYC=4, IReq_FE=1, MemAck_SY never -> MemReq_SY drops after 4 BUSY cycles, IAck_FE pulses, IData_FE=0, BusErr=1 held.
REQ-023 reset asserted in BUSY_D, then MemAck_SY=1 one cycle later -> no DAck_ME, MemReq_SY=0, all outputs 0.
REQ-024 MemAck_SY asserted in same cycle counter hits TIMEOUT_CYC -> real data returned, BusErr=0.
REQ-025 Back-to-back fetches, IReq_FE held high 3 acks -> three IAck_FE pulses, each separated by >=2 cycles.
